dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory RAM port between CPUS cores of the multicore processor.
- Round-robin arbitration, one outstanding RAM transaction at a time.
- Holds a per-core link register for LL/SC atomics, decoded upstream from the LL/SC opcodes as dREN/dWEN plus datomic.
- Sits between each core's data-side request lines and the memory controller's RAM interface.

Parameters:
- CPUS, 2: number of requesting cores; supported range 2..4.

Ports:
- CLK  in  1  system clock. One clock domain.
- nRST  in  1  reset; asynchronous, active-low.
- dREN  in  [CPUS]  per-core read request; LL when datomic is set.
- dWEN  in  [CPUS]  per-core write request; SC when datomic is set.
- datomic  in  [CPUS]  marks the request as LL/SC.
- daddr  in  [CPUS] x word_t  byte address; bits [1:0] are ignored.
- dstore  in  [CPUS] x word_t  write data.
- dwait  out  [CPUS]  1 = request pending/not done; 0 for exactly one cycle on completion.
- dload  out  [CPUS] x word_t  read data, or SC result (1 = success, 0 = fail).
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  word_t  RAM address.
- ramstore  out  word_t  RAM write data.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Behaviour:
- Reset (async, nRST=0) forces:
  - state IDLE; rr_last = CPUS-1, so core 0 wins first.
  - all link_valid = 0; all link_addr = 0.
  - dwait = all 1s; dload = 0.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Reset mid-transaction: RAM strobes drop asynchronously and the transaction is abandoned. Cores must reissue.
- A request is (dREN|dWEN)[i]. dREN and dWEN both high is illegal; it is treated as a write.
- The core holds its request stable until it sees dwait[i]=0. It may drop or change the request on the following cycle.
- dwait[i] = 0 only in RESP, and only for the granted core. All other cycles it is 1.
- States:
  - IDLE
    - No request: stay in IDLE.
    - Otherwise pick the first requester after rr_last in circular order. Register grant, addr, data and op.
    - SC with link_valid[g]=0 or link_addr[g] != daddr[g][31:2]: go to RESP with result 0, no RAM access.
    - Everything else: go to GRANT. Update rr_last = g.
  - GRANT
    - Drive ramREN/ramWEN, ramaddr and ramstore from the registered values. Strobes stay on for every GRANT cycle.
    - ramstate ACCESS: latch the result (ramload for a read, 1 for SC, 0 for a plain write), then go to RESP.
    - BUSY/FREE: stay in GRANT.
    - ERROR: stay in GRANT and keep strobes high (retry).
  - RESP
    - One cycle with dwait[g]=0 and dload[g] = latched result. Then return to IDLE.
- Minimum latency:
  - Request seen in IDLE (cycle 0), GRANT cycle 1, ACCESS in cycle 1, dwait low in cycle 2.
  - Failed SC: dwait low in cycle 1.
- Back-to-back: RESP -> IDLE -> next grant. There is one idle arbitration cycle between transactions.
- Fairness: with continuous requests from all cores, grants rotate 0,1,..,CPUS-1.
- Link registers:
  - LL completion (ACCESS): link_addr[g] = addr[31:2], link_valid[g] = 1.
  - Any write completion (plain SW or successful SC, from any core, including g): clear link_valid[j] for every j with link_addr[j] == addr[31:2].
  - A successful SC therefore clears its own link.
  - A failed SC clears link_valid[g].
  - A second LL by the same core overwrites its link.
- dload[i] for non-granted cores holds its last value.

Decomposition:
- cpu_types_pkg provides word_t and ramstate_t.
- Add arb_state_t {IDLE, GRANT, RESP} to cpu_types_pkg.
- Sub-module rr_picker: combinational priority rotate over CPUS request bits. Inputs req and last; outputs onehot and idx.

Test Plan:
- Single read: core0 dREN, daddr=0x100, RAM ACCESS in 1st GRANT cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 1 cycle; dwait[0]=0 and dload[0]=0xDEADBEEF 2 cycles after request.
- Contention: both cores request continuously from reset, ramstate=ACCESS -> grant order 0,1,0,1; each RESP 3 cycles apart; the other core's dwait stays 1.
- LL/SC success: core0 LL 0x200, then SC 0x200 with dstore=5 -> ramWEN=1, ramstore=5; dload[0]=1; link_valid[0]=0 afterward.
- LL/SC broken: core0 LL 0x200; core1 SW 0x200; core0 SC 0x200 -> no ramWEN for the SC; dload[0]=0 one cycle after the SC is seen.
- Wait states/error: ramstate BUSY 3 cycles, then ERROR 1 cycle, then ACCESS -> strobes held for all 5 GRANT cycles; single RESP after.
- Reset mid-GRANT: nRST low while ramWEN=1 -> ramWEN=0 immediately; after release the state is IDLE, links are cleared and all dwait=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the data-memory path: word, RAM handshake state and
// the arbiter's state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester strictly after 'last'
// in circular order. Outputs a one-hot grant and its index.
module rr_picker #(
   parameter  int CPUS = 2,
   localparam int IW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
   input  logic [CPUS-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [CPUS-1:0] onehot,
   output logic [IW-1:0]   idx
);

   logic [IW:0]       shift_amt;
   logic [2*CPUS-1:0] req_dbl;
   logic [2*CPUS-1:0] req_rot_dbl;
   logic [CPUS-1:0]   req_rot;
   logic [CPUS-1:0]   win_rot;
   logic [2*CPUS-1:0] win_dbl;
   logic [IW-1:0]     idx_acc [CPUS+1];

   // Rotate so that bit 0 is the core right after 'last', isolate the lowest
   // set bit, then rotate the winner back into core numbering.
   assign shift_amt   = {1'b0, last} + {{IW{1'b0}}, 1'b1};
   assign req_dbl     = {req, req};
   assign req_rot_dbl = req_dbl >> shift_amt;
   assign req_rot     = req_rot_dbl[CPUS-1:0];
   assign win_rot     = req_rot & (~req_rot + {{(CPUS-1){1'b0}}, 1'b1});
   assign win_dbl     = {win_rot, win_rot} << shift_amt;
   assign onehot      = win_dbl[2*CPUS-1:CPUS];

   assign idx_acc[0] = '0;
   generate
      for (genvar gi = 0; gi < CPUS; gi++) begin : g_idx
         assign idx_acc[gi+1] = idx_acc[gi] | (onehot[gi] ? IW'(gi) : {IW{1'b0}});
      end
   endgenerate
   assign idx = idx_acc[CPUS];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPUS cores, one
// transaction in flight, with per-core LL/SC link registers.
module dmem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [CPUS-1:0]   dREN,
   input  logic [CPUS-1:0]   dWEN,
   input  logic [CPUS-1:0]   datomic,
   input  logic [31:0]       daddr  [CPUS],
   input  logic [31:0]       dstore [CPUS],
   output logic [CPUS-1:0]   dwait,
   output logic [31:0]       dload  [CPUS],
   output logic              ramREN,
   output logic              ramWEN,
   output logic [31:0]       ramaddr,
   output logic [31:0]       ramstore,
   input  logic [31:0]       ramload,
   input  ramstate_t         ramstate
);

   localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

   arb_state_t             state_reg;
   logic [IW-1:0]          rr_last_reg;
   logic [IW-1:0]          grant_reg;
   logic [29:0]            addr_reg;
   logic                   write_reg;
   logic                   atomic_reg;
   logic [CPUS-1:0]        link_valid_reg;
   logic [CPUS-1:0][29:0]  link_addr_reg;
   logic [CPUS-1:0][31:0]  dload_reg;
   logic [CPUS-1:0]        dwait_reg;
   logic                   ram_ren_reg;
   logic                   ram_wen_reg;
   logic [31:0]            ram_addr_reg;
   logic [31:0]            ram_store_reg;

   logic [CPUS-1:0]        req;
   logic [CPUS-1:0]        link_hit;
   logic [CPUS-1:0]        pick_onehot;
   logic [CPUS-1:0]        grant_onehot;
   logic [IW-1:0]          pick_idx;
   logic                   pick_write;
   logic                   pick_atomic;
   logic [29:0]            pick_waddr;
   logic                   sc_fail;

   generate
      for (genvar gi = 0; gi < CPUS; gi++) begin : g_core
         assign req[gi]      = dREN[gi] | dWEN[gi];
         assign link_hit[gi] = (link_addr_reg[gi] == addr_reg);
         assign dload[gi]    = dload_reg[gi];
      end
   endgenerate

   rr_picker #(.CPUS(CPUS)) u_picker (
      .req    (req),
      .last   (rr_last_reg),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Read+write together is resolved as a write.
   assign pick_write   = dWEN[pick_idx];
   assign pick_atomic  = datomic[pick_idx];
   assign pick_waddr   = daddr[pick_idx][31:2];
   assign sc_fail      = pick_write & pick_atomic &
                         (~link_valid_reg[pick_idx] | (link_addr_reg[pick_idx] != pick_waddr));
   assign grant_onehot = {{(CPUS-1){1'b0}}, 1'b1} << grant_reg;

   assign dwait    = dwait_reg;
   assign ramREN   = ram_ren_reg;
   assign ramWEN   = ram_wen_reg;
   assign ramaddr  = ram_addr_reg;
   assign ramstore = ram_store_reg;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg      <= IDLE;
         rr_last_reg    <= IW'(CPUS - 1);
         grant_reg      <= '0;
         addr_reg       <= '0;
         write_reg      <= 1'b0;
         atomic_reg     <= 1'b0;
         link_valid_reg <= '0;
         link_addr_reg  <= '0;
         dload_reg      <= '0;
         dwait_reg      <= '1;
         ram_ren_reg    <= 1'b0;
         ram_wen_reg    <= 1'b0;
         ram_addr_reg   <= '0;
         ram_store_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  grant_reg  <= pick_idx;
                  addr_reg   <= pick_waddr;
                  write_reg  <= pick_write;
                  atomic_reg <= pick_atomic;
                  if (sc_fail) begin
                     // Failed SC answers straight away and never touches RAM.
                     link_valid_reg[pick_idx] <= 1'b0;
                     dload_reg[pick_idx]      <= '0;
                     dwait_reg                <= ~pick_onehot;
                     state_reg                <= RESP;
                  end else begin
                     rr_last_reg   <= pick_idx;
                     ram_ren_reg   <= ~pick_write;
                     ram_wen_reg   <= pick_write;
                     ram_addr_reg  <= daddr[pick_idx];
                     ram_store_reg <= dstore[pick_idx];
                     state_reg     <= GRANT;
                  end
               end
            end
            GRANT: begin
               // Strobes stay up through BUSY/FREE/ERROR until ACCESS.
               if (ramstate == ACCESS) begin
                  ram_ren_reg <= 1'b0;
                  ram_wen_reg <= 1'b0;
                  dwait_reg   <= ~grant_onehot;
                  state_reg   <= RESP;
                  if (write_reg) begin
                     dload_reg[grant_reg] <= atomic_reg ? 32'd1 : 32'd0;
                     link_valid_reg       <= link_valid_reg & ~link_hit;
                  end else begin
                     dload_reg[grant_reg] <= ramload;
                     if (atomic_reg) begin
                        link_addr_reg[grant_reg]  <= addr_reg;
                        link_valid_reg[grant_reg] <= 1'b1;
                     end
                  end
               end
            end
            RESP: begin
               dwait_reg <= '1;
               state_reg <= IDLE;
            end
            default: begin
               dwait_reg <= '1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM responder with scripted wait states plus a
// behavioural memory/link model; directed scenarios and random traffic.
module tb_dmem_arbiter;
   import cpu_types_pkg::*;

   localparam int CPUS = 2;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic [CPUS-1:0]  dREN = '0;
   logic [CPUS-1:0]  dWEN = '0;
   logic [CPUS-1:0]  datomic = '0;
   logic [31:0]      daddr  [CPUS];
   logic [31:0]      dstore [CPUS];
   logic [CPUS-1:0]  dwait;
   logic [31:0]      dload  [CPUS];
   logic             ramREN;
   logic             ramWEN;
   logic [31:0]      ramaddr;
   logic [31:0]      ramstore;
   logic [31:0]      ramload = '0;
   ramstate_t        ramstate = FREE;

   int checks = 0;
   int errors = 0;

   // RAM environment
   ramstate_t script[$];
   word_t     ram_mem [word_t];
   int        ram_cycles = 0;
   int        ram_wr_done = 0;
   word_t     last_ram_addr = '0;
   word_t     last_ram_store = '0;

   // Reference model
   word_t     model_mem [word_t];
   bit        link_v [CPUS];
   word_t     link_a [CPUS];

   always #5 CLK = ~CLK;

   dmem_arbiter #(.CPUS(CPUS)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .datomic  (datomic),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   function automatic word_t mem_dflt(input word_t wa);
      return 32'hDEADBEEF ^ ((wa - 32'h40) * 32'h0100_0193);
   endfunction

   function automatic word_t ram_rd(input word_t wa);
      if (ram_mem.exists(wa)) return ram_mem[wa];
      return mem_dflt(wa);
   endfunction

   function automatic word_t model_rd(input word_t wa);
      if (model_mem.exists(wa)) return model_mem[wa];
      return mem_dflt(wa);
   endfunction

   // Memory controller stand-in: ramstate for the current cycle is set on
   // the falling edge from the script (ACCESS when the script is empty).
   always @(negedge CLK) begin
      ramstate_t st;
      if (ramREN || ramWEN) begin
         st = ACCESS;
         if (script.size() > 0) st = script.pop_front();
         ramstate = st;
         ram_cycles++;
         last_ram_addr = ramaddr;
         if (ramWEN) last_ram_store = ramstore;
         if (st == ACCESS) begin
            if (ramWEN) begin
               ram_mem[ramaddr >> 2] = ramstore;
               ram_wr_done++;
            end else begin
               ramload = ram_rd(ramaddr >> 2);
            end
         end
      end else begin
         ramstate = FREE;
      end
   end

   // op: 0 LW, 1 SW, 2 LL, 3 SC
   function automatic void model_op(input int c, input int op, input word_t addr,
                                    input word_t data, output word_t exp,
                                    output bit exp_ram, output bit exp_wr);
      word_t wa;
      wa = addr >> 2;
      exp = '0;
      exp_ram = 1'b1;
      exp_wr = (op == 1 || op == 3);
      if (op == 0) begin
         exp = model_rd(wa);
      end else if (op == 2) begin
         exp = model_rd(wa);
         link_v[c] = 1'b1;
         link_a[c] = wa;
      end else if (op == 3 && !(link_v[c] && link_a[c] == wa)) begin
         link_v[c] = 1'b0;
         exp_ram = 1'b0;
         exp_wr = 1'b0;
      end else begin
         model_mem[wa] = data;
         exp = (op == 3) ? 32'd1 : 32'd0;
         for (int j = 0; j < CPUS; j++)
            if (link_v[j] && link_a[j] == wa) link_v[j] = 1'b0;
      end
   endfunction

   task automatic issue_op(input int c, input int op, input word_t addr, input word_t data,
                           output word_t got, output int lat, output bit other_low);
      @(negedge CLK);
      daddr[c]   = addr;
      dstore[c]  = data;
      dREN[c]    = (op == 0 || op == 2);
      dWEN[c]    = (op == 1 || op == 3);
      datomic[c] = (op >= 2);
      lat = -1;
      got = '0;
      other_low = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         for (int j = 0; j < CPUS; j++)
            if (j != c && dwait[j] == 1'b0) other_low = 1'b1;
         if (dwait[c] == 1'b0) begin
            lat = k;
            got = dload[c];
            break;
         end
      end
      dREN[c] = 1'b0;
      dWEN[c] = 1'b0;
      datomic[c] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      dREN = '0;
      dWEN = '0;
      datomic = '0;
      script.delete();
      for (int j = 0; j < CPUS; j++) begin
         link_v[j] = 1'b0;
         link_a[j] = '0;
      end
      repeat (3) @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if (dwait !== '1) begin
         errors++; $display("FAIL reset_dwait got %b exp all ones", dwait);
      end
      for (int j = 0; j < CPUS; j++) begin
         checks++;
         if (dload[j] !== 32'h0) begin
            errors++; $display("FAIL reset_dload core %0d got %h exp 0", j, dload[j]);
         end
      end
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         errors++; $display("FAIL reset_strobes got ren=%b wen=%b exp 0/0", ramREN, ramWEN);
      end
      checks++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         errors++; $display("FAIL reset_ram_bus got addr=%h store=%h exp 0/0", ramaddr, ramstore);
      end
   endtask

   task automatic test_contention();
      int    ev_k[$];
      int    ev_c[$];
      word_t ev_v[$];
      int    n;
      for (int j = 0; j < CPUS; j++) begin
         daddr[j] = 32'h1000 + 32'(16 * j);
         dREN[j]  = 1'b1;
      end
      for (int k = 1; k <= 6 * CPUS; k++) begin
         @(negedge CLK);
         for (int j = 0; j < CPUS; j++)
            if (dwait[j] == 1'b0) begin
               ev_k.push_back(k); ev_c.push_back(j); ev_v.push_back(dload[j]);
            end
      end
      dREN = '0;
      checks++;
      if (ev_k.size() != 2 * CPUS) begin
         errors++; $display("FAIL contention_count got %0d exp %0d", ev_k.size(), 2 * CPUS);
      end
      n = (ev_k.size() < 2 * CPUS) ? ev_k.size() : 2 * CPUS;
      for (int e = 0; e < n; e++) begin
         checks++;
         if (ev_c[e] != e % CPUS || ev_k[e] != 2 + 3 * e) begin
            errors++;
            $display("FAIL contention_order ev %0d got core %0d cycle %0d exp core %0d cycle %0d",
                     e, ev_c[e], ev_k[e], e % CPUS, 2 + 3 * e);
         end
         checks++;
         if (ev_v[e] !== model_rd((32'h1000 + 32'(16 * ev_c[e])) >> 2)) begin
            errors++; $display("FAIL contention_data ev %0d got %h exp %h", e, ev_v[e],
                               model_rd((32'h1000 + 32'(16 * ev_c[e])) >> 2));
         end
      end
   endtask

   task automatic test_single_read();
      word_t got, exp;
      int    lat, rc0;
      bit    ol, er, ew;
      model_op(0, 0, 32'h100, 32'h0, exp, er, ew);
      rc0 = ram_cycles;
      issue_op(0, 0, 32'h100, 32'h0, got, lat, ol);
      checks++;
      if (got !== 32'hDEADBEEF || got !== exp) begin
         errors++; $display("FAIL single_read_data got %h exp %h", got, 32'hDEADBEEF);
      end
      checks++;
      if (lat != 2) begin
         errors++; $display("FAIL single_read_latency got %0d exp 2", lat);
      end
      checks++;
      if (ram_cycles - rc0 != 1 || last_ram_addr !== 32'h100) begin
         errors++; $display("FAIL single_read_ram got cycles=%0d addr=%h exp 1/00000100",
                            ram_cycles - rc0, last_ram_addr);
      end
   endtask

   task automatic test_llsc_success();
      word_t got, exp;
      int    lat, wc0;
      bit    ol, er, ew;
      model_op(0, 2, 32'h200, 32'h0, exp, er, ew);
      issue_op(0, 2, 32'h200, 32'h0, got, lat, ol);
      checks++;
      if (got !== exp || lat != 2) begin
         errors++; $display("FAIL ll_load got %h lat %0d exp %h lat 2", got, lat, exp);
      end
      model_op(0, 3, 32'h200, 32'd5, exp, er, ew);
      wc0 = ram_wr_done;
      issue_op(0, 3, 32'h200, 32'd5, got, lat, ol);
      checks++;
      if (got !== 32'd1 || got !== exp) begin
         errors++; $display("FAIL sc_success_result got %h exp 1", got);
      end
      checks++;
      if (ram_wr_done - wc0 != 1 || last_ram_store !== 32'd5) begin
         errors++; $display("FAIL sc_success_write got writes=%0d store=%h exp 1/5",
                            ram_wr_done - wc0, last_ram_store);
      end
      // the link was consumed, so a repeat SC must fail
      model_op(0, 3, 32'h200, 32'd6, exp, er, ew);
      wc0 = ram_wr_done;
      issue_op(0, 3, 32'h200, 32'd6, got, lat, ol);
      checks++;
      if (got !== 32'd0 || lat != 1 || ram_wr_done != wc0) begin
         errors++; $display("FAIL sc_repeat got %h lat %0d writes %0d exp 0 lat 1 writes 0",
                            got, lat, ram_wr_done - wc0);
      end
   endtask

   task automatic test_llsc_broken();
      word_t got, exp;
      int    lat, wc0;
      bit    ol, er, ew;
      model_op(0, 2, 32'h200, 32'h0, exp, er, ew);
      issue_op(0, 2, 32'h200, 32'h0, got, lat, ol);
      model_op(1, 1, 32'h200, 32'h1234_5678, exp, er, ew);
      issue_op(1, 1, 32'h200, 32'h1234_5678, got, lat, ol);
      checks++;
      if (got !== 32'd0 || lat != 2) begin
         errors++; $display("FAIL sw_core1 got %h lat %0d exp 0 lat 2", got, lat);
      end
      model_op(0, 3, 32'h200, 32'd9, exp, er, ew);
      wc0 = ram_wr_done;
      issue_op(0, 3, 32'h200, 32'd9, got, lat, ol);
      checks++;
      if (got !== 32'd0 || got !== exp) begin
         errors++; $display("FAIL sc_broken_result got %h exp 0", got);
      end
      checks++;
      if (lat != 1 || ram_wr_done != wc0) begin
         errors++; $display("FAIL sc_broken_timing got lat %0d writes %0d exp 1/0", lat, ram_wr_done - wc0);
      end
   endtask

   task automatic test_wait_states();
      word_t got, exp;
      int    lat, rc0;
      bit    ol, er, ew;
      model_op(1, 0, 32'h104, 32'h0, exp, er, ew);
      script.push_back(BUSY); script.push_back(BUSY); script.push_back(BUSY);
      script.push_back(ERROR);
      rc0 = ram_cycles;
      issue_op(1, 0, 32'h104, 32'h0, got, lat, ol);
      checks++;
      if (lat != 6 || ram_cycles - rc0 != 5) begin
         errors++; $display("FAIL wait_states got lat %0d strobe cycles %0d exp 6/5", lat, ram_cycles - rc0);
      end
      checks++;
      if (got !== exp || ol) begin
         errors++; $display("FAIL wait_data got %h other_low %0d exp %h 0", got, ol, exp);
      end
      @(negedge CLK);
      checks++;
      if (dwait !== '1) begin
         errors++; $display("FAIL wait_single_resp got dwait %b exp all ones", dwait);
      end
   endtask

   task automatic test_random_arb();
      bit    pend [CPUS];
      int    last, exp_c, win, idx;
      word_t a;
      do_reset();
      last = CPUS - 1;
      for (int j = 0; j < CPUS; j++) pend[j] = 1'b0;
      for (int r = 0; r < 24; r++) begin
         for (int j = 0; j < CPUS; j++)
            if (!pend[j] && $urandom_range(0, 1) == 1) begin
               pend[j] = 1'b1;
               daddr[j] = 32'h2000 + 32'($urandom_range(0, 63) * 4);
               dREN[j] = 1'b1;
            end
         if (!(pend[0] || pend[1])) begin
            idx = r % CPUS;
            pend[idx] = 1'b1;
            daddr[idx] = 32'h2000 + 32'($urandom_range(0, 63) * 4);
            dREN[idx] = 1'b1;
         end
         exp_c = -1;
         for (int k = 1; k <= CPUS; k++)
            if (exp_c < 0 && pend[(last + k) % CPUS]) exp_c = (last + k) % CPUS;
         win = -1;
         for (int t = 0; t < 20 && win < 0; t++) begin
            @(negedge CLK);
            for (int j = 0; j < CPUS; j++)
               if (win < 0 && dwait[j] == 1'b0) win = j;
         end
         checks++;
         if (win != exp_c) begin
            errors++; $display("FAIL arb_winner round %0d got %0d exp %0d", r, win, exp_c);
         end
         if (win < 0) break;
         a = daddr[win];
         checks++;
         if (dload[win] !== model_rd(a >> 2)) begin
            errors++; $display("FAIL arb_data round %0d got %h exp %h", r, dload[win], model_rd(a >> 2));
         end
         pend[win] = 1'b0;
         dREN[win] = 1'b0;
         last = win;
      end
      dREN = '0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_random_ops();
      word_t addrs [4];
      word_t a, d, got, exp;
      int    c, op, nw, lat, rc0, wc0, exp_lat, exp_rc;
      bit    er, ew, ol;
      addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h300; addrs[3] = 32'h100;
      for (int n = 0; n < 80; n++) begin
         c  = $urandom_range(0, CPUS - 1);
         op = $urandom_range(0, 3);
         a  = addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
         d  = $urandom;
         nw = $urandom_range(0, 2);
         model_op(c, op, a, d, exp, er, ew);
         if (er) begin
            for (int w = 0; w < nw; w++) begin
               case ($urandom_range(0, 2))
                  0:       script.push_back(BUSY);
                  1:       script.push_back(ERROR);
                  default: script.push_back(FREE);
               endcase
            end
         end
         exp_lat = er ? 2 + nw : 1;
         exp_rc  = er ? 1 + nw : 0;
         rc0 = ram_cycles;
         wc0 = ram_wr_done;
         issue_op(c, op, a, d, got, lat, ol);
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL rand_data op#%0d core %0d op %0d addr %h got %h exp %h", n, c, op, a, got, exp);
         end
         checks++;
         if (lat != exp_lat || ram_cycles - rc0 != exp_rc) begin
            errors++; $display("FAIL rand_timing op#%0d got lat %0d strobes %0d exp %0d/%0d",
                               n, lat, ram_cycles - rc0, exp_lat, exp_rc);
         end
         checks++;
         if (ram_wr_done - wc0 != int'(ew) || ol) begin
            errors++; $display("FAIL rand_side op#%0d got writes %0d other_low %0d exp %0d/0",
                               n, ram_wr_done - wc0, ol, int'(ew));
         end
      end
   endtask

   task automatic test_reset_mid();
      word_t got, exp;
      int    lat, wc0;
      bit    ol, er, ew;
      model_op(0, 2, 32'h300, 32'h0, exp, er, ew);
      issue_op(0, 2, 32'h300, 32'h0, got, lat, ol);
      @(negedge CLK);
      for (int w = 0; w < 6; w++) script.push_back(BUSY);
      daddr[1] = 32'h380; dstore[1] = 32'hCAFE_F00D; dWEN[1] = 1'b1;
      @(negedge CLK);
      checks++;
      if (ramWEN !== 1'b1) begin
         errors++; $display("FAIL midreset_pre got ramWEN %b exp 1", ramWEN);
      end
      #2 nRST = 1'b0;
      #1;
      checks++;
      if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin
         errors++; $display("FAIL midreset_async got ren=%b wen=%b exp 0/0", ramREN, ramWEN);
      end
      dWEN = '0; dREN = '0; datomic = '0;
      script.delete();
      for (int j = 0; j < CPUS; j++) link_v[j] = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      checks++;
      if (dwait !== '1 || ramWEN !== 1'b0) begin
         errors++; $display("FAIL midreset_idle got dwait %b wen %b exp ones/0", dwait, ramWEN);
      end
      model_op(0, 3, 32'h300, 32'd7, exp, er, ew);
      wc0 = ram_wr_done;
      issue_op(0, 3, 32'h300, 32'd7, got, lat, ol);
      checks++;
      if (got !== exp || lat != 1 || ram_wr_done != wc0) begin
         errors++; $display("FAIL midreset_link got %h lat %0d writes %0d exp %h lat 1 writes 0",
                            got, lat, ram_wr_done - wc0, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int j = 0; j < CPUS; j++) begin
         daddr[j] = '0;
         dstore[j] = '0;
      end
      do_reset();
      test_reset();
      test_contention();
      test_single_read();
      test_llsc_success();
      test_llsc_broken();
      test_wait_states();
      test_random_arb();
      test_random_ops();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
